// File: rtl/icache_if.sv
// icache_if: fetch-side and memory-side handshake bundle of the instruction cache
interface icache_if;
  logic        from_if_valid;
  logic [31:0] from_if_pc;
  logic        to_if_ready;
  logic [31:0] to_if_inst;
  logic        to_mem_req;
  logic [31:0] to_mem_addr;
  logic        from_mem_ready;
  logic [31:0] from_mem_data;
  modport master(
    output from_if_valid, from_if_pc, from_mem_ready, from_mem_data,
    input  to_if_ready, to_if_inst, to_mem_req, to_mem_addr
  );
  modport slave(
    input  from_if_valid, from_if_pc, from_mem_ready, from_mem_data,
    output to_if_ready, to_if_inst, to_mem_req, to_mem_addr
  );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped one-word-per-line instruction cache with clear-cancellable miss handling
module icache #(
  parameter int INDEX_BITS = 6
) (
  input logic      clk,
  input logic      rst,
  input logic      rdy,
  input logic      clear,
  icache_if.slave  b
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TW = 30 - INDEX_BITS;
  typedef enum logic [1:0] {IDLE, MISS, DROP} state_t;
  state_t                  state_q, state_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [TW-1:0]           tag_q [LINES];
  logic [31:0]             data_q [LINES];
  logic                    ready_q, ready_d;
  logic [31:0]             inst_q, inst_d;
  logic                    req_q, req_d;
  logic [31:0]             addr_q, addr_d;
  logic [INDEX_BITS-1:0]   midx_q, midx_d;
  logic [TW-1:0]           mtag_q, mtag_d;
  logic [INDEX_BITS-1:0]   idx;
  logic [TW-1:0]           tag;
  logic                    hit;
  logic                    fill;
  assign idx  = b.from_if_pc[INDEX_BITS+1:2];
  assign tag  = b.from_if_pc[31:INDEX_BITS+2];
  assign hit  = valid_q[idx] && tag_q[idx] == tag;
  assign fill = state_q == MISS && !clear && b.from_mem_ready;
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ready_d = 1'b0;
    inst_d  = inst_q;
    req_d   = req_q;
    addr_d  = addr_q;
    midx_d  = midx_q;
    mtag_d  = mtag_q;
    case (state_q)
      IDLE: if (b.from_if_valid && !ready_q && !clear) begin
        if (hit) begin
          ready_d = 1'b1;
          inst_d  = data_q[idx];
        end else begin
          req_d   = 1'b1;
          addr_d  = b.from_if_pc & ~32'd3;
          midx_d  = idx;
          mtag_d  = tag;
          state_d = MISS;
        end
      end
      MISS: if (clear) begin
        req_d   = 1'b0;
        state_d = DROP;
      end else if (fill) begin
        valid_d[midx_q] = 1'b1;
        ready_d = 1'b1;
        inst_d  = b.from_mem_data;
        req_d   = 1'b0;
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      ready_q <= 1'b0;
      inst_q  <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      midx_q  <= '0;
      mtag_q  <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      inst_q  <= inst_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      midx_q  <= midx_d;
      mtag_q  <= mtag_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill) begin
      tag_q[midx_q]  <= mtag_q;
      data_q[midx_q] <= b.from_mem_data;
    end
  end
  assign b.to_if_ready = ready_q;
  assign b.to_if_inst  = inst_q;
  assign b.to_mem_req  = req_q;
  assign b.to_mem_addr = addr_q;
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed and randomized checks of icache against a line-address reference model
module tb_icache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic clear = 1'b0;
  icache_if bus();
  icache #(.INDEX_BITS(6)) dut (.clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .b(bus));
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  bit last_pulse = 1'b0;
  int unsigned res [int];
  logic [31:0] rdata [int];
  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction
  function automatic bit is_hit(logic [31:0] pc);
    return res.exists(idx_of(pc)) && res[idx_of(pc)] == (pc >> 2);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string t, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", t, got, exp);
    end
  endtask
  task automatic request(logic [31:0] pc);
    bus.from_if_valid = 1'b1;
    bus.from_if_pc = pc;
    tick();
    if (last_pulse) begin
      chk("gap_ready", 32'(bus.to_if_ready), 0);
      tick();
    end
    last_pulse = 1'b0;
  endtask
  task automatic fetch(logic [31:0] pc, logic [31:0] data, int delay);
    bit h;
    h = is_hit(pc);
    request(pc);
    if (h) begin
      chk("hit_ready", 32'(bus.to_if_ready), 1);
      chk("hit_inst", bus.to_if_inst, rdata[idx_of(pc)]);
      chk("hit_noreq", 32'(bus.to_mem_req), 0);
    end else begin
      chk("miss_req", 32'(bus.to_mem_req), 1);
      chk("miss_addr", bus.to_mem_addr, pc & ~32'd3);
      chk("miss_ready", 32'(bus.to_if_ready), 0);
      repeat (delay) begin
        tick();
        chk("wait_req", 32'(bus.to_mem_req), 1);
        chk("wait_addr", bus.to_mem_addr, pc & ~32'd3);
      end
      bus.from_mem_ready = 1'b1;
      bus.from_mem_data = data;
      tick();
      chk("fill_ready", 32'(bus.to_if_ready), 1);
      chk("fill_inst", bus.to_if_inst, data);
      chk("fill_req", 32'(bus.to_mem_req), 0);
      chk("fill_addr", bus.to_mem_addr, 0);
      bus.from_mem_ready = 1'b0;
      res[idx_of(pc)] = pc >> 2;
      rdata[idx_of(pc)] = data;
    end
    bus.from_if_valid = 1'b0;
    last_pulse = 1'b1;
  endtask
  task automatic miss_clear(logic [31:0] pc, int delay, bit coinc);
    request(pc);
    chk("mc_req", 32'(bus.to_mem_req), 1);
    repeat (delay) tick();
    clear = 1'b1;
    bus.from_mem_ready = coinc;
    bus.from_mem_data = 32'hDEAD_BEEF;
    tick();
    chk("mc_req_drop", 32'(bus.to_mem_req), 0);
    chk("mc_noready", 32'(bus.to_if_ready), 0);
    clear = 1'b0;
    bus.from_mem_ready = 1'b0;
    bus.from_if_valid = 1'b0;
    tick();
    chk("drop_noready", 32'(bus.to_if_ready), 0);
    chk("drop_noreq", 32'(bus.to_mem_req), 0);
  endtask
  task automatic rdy_miss(logic [31:0] pc, logic [31:0] data);
    request(pc);
    chk("rm_req", 32'(bus.to_mem_req), 1);
    rdy = 1'b0;
    bus.from_mem_ready = 1'b1;
    bus.from_mem_data = 32'hBAD0_BAD0;
    repeat (5) begin
      tick();
      chk("frz_req", 32'(bus.to_mem_req), 1);
      chk("frz_addr", bus.to_mem_addr, pc & ~32'd3);
      chk("frz_ready", 32'(bus.to_if_ready), 0);
    end
    bus.from_mem_ready = 1'b0;
    rdy = 1'b1;
    tick();
    chk("rm_req_after", 32'(bus.to_mem_req), 1);
    bus.from_mem_ready = 1'b1;
    bus.from_mem_data = data;
    tick();
    chk("rm_fill_ready", 32'(bus.to_if_ready), 1);
    chk("rm_fill_inst", bus.to_if_inst, data);
    chk("rm_fill_req", 32'(bus.to_mem_req), 0);
    bus.from_mem_ready = 1'b0;
    bus.from_if_valid = 1'b0;
    res[idx_of(pc)] = pc >> 2;
    rdata[idx_of(pc)] = data;
    last_pulse = 1'b1;
  endtask
  initial begin
    logic [31:0] pc;
    bus.from_if_valid = 1'b0;
    bus.from_if_pc = '0;
    bus.from_mem_ready = 1'b0;
    bus.from_mem_data = '0;
    tick();
    tick();
    chk("rst_ready", 32'(bus.to_if_ready), 0);
    chk("rst_inst", bus.to_if_inst, 0);
    chk("rst_req", 32'(bus.to_mem_req), 0);
    chk("rst_addr", bus.to_mem_addr, 0);
    rst = 1'b0;
    fetch(32'h4, 32'h00A0_0093, 5);
    fetch(32'h4, 32'h0, 0);
    fetch(32'h0, 32'h11, 2);
    fetch(32'h100, 32'h22, 2);
    fetch(32'h0, 32'h11, 1);
    miss_clear(32'h40, 2, 1'b0);
    fetch(32'h40, 32'h4040_4040, 1);
    miss_clear(32'h80, 1, 1'b1);
    fetch(32'h80, 32'h8080_8080, 0);
    rdy_miss(32'hC, 32'h0C0C_0C0C);
    fetch(32'hC, 32'h0, 0);
    fetch(32'h8, 32'h0000_0888, 3);
    fetch(32'h0, 32'h0, 0);
    fetch(32'h4, 32'h0, 0);
    fetch(32'h8, 32'h0, 0);
    tick();
    chk("no_double", 32'(bus.to_if_ready), 0);
    last_pulse = 1'b0;
    request(32'h200);
    chk("rm_rst_req", 32'(bus.to_mem_req), 1);
    rst = 1'b1;
    tick();
    chk("rst_mid_req", 32'(bus.to_mem_req), 0);
    chk("rst_mid_ready", 32'(bus.to_if_ready), 0);
    chk("rst_mid_addr", bus.to_mem_addr, 0);
    rst = 1'b0;
    bus.from_if_valid = 1'b0;
    res.delete();
    rdata.delete();
    fetch(32'h4, 32'h00A0_0093, 1);
    for (int i = 0; i < 80; i++) begin
      pc = 32'($urandom_range(0, 511)) << 2;
      if (!is_hit(pc) && $urandom_range(0, 5) == 0)
        miss_clear(pc, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      else
        fetch(pc, (pc * 32'h9E37_79B1) ^ 32'h5A5A_0000, $urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) begin
        tick();
        last_pulse = 1'b0;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
